muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that produces the HI/LO results for MULT, MULTU, DIV and DIVU.
- Feeds the currently unused "a" leg of the hi/lo select muxes beside cpu55, and drives the reg_hi/reg_lo write enables.
- Interlocks the CPU so that mfhi/mflo/mthi/mtlo and new mul/div ops never race an in-flight operation.
- One operand pair accepted at a time; results are committed in a single cycle.

Parameters:
- WIDTH, 32, operand width. The iteration count equals WIDTH; the counter width is derived as clog2(WIDTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  mul/div instruction issued this cycle (from cpu55 decode).
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  in  WIDTH  multiplicand / dividend.
- rt_val  in  WIDTH  multiplier / divisor.
- mfhi, mflo, mthi, mtlo  in  1 each  CPU hi/lo access strobes.
- busy  out  1  operation in progress (state != IDLE).
- stall  out  1  CPU must hold its current instruction.
- hi_we  out  1  HI write enable from this block; ORed with mthi for the reg_hi ena.
- lo_we  out  1  LO write enable; ORed with mtlo for the reg_lo ena.
- hi_wdata  out  WIDTH  result for HI: product high word, or remainder.
- lo_wdata  out  WIDTH  result for LO: product low word, or quotient.
- div_zero  out  1  one-cycle flag during DONE when a DIV/DIVU had divisor 0.

Behaviour:
- Reset (rst=0, asynchronous) forces the state to IDLE and clears all internal registers. All outputs read 0.
- State IDLE:
  - start=1 latches op, the operand magnitudes (two's-complement absolute value for MULT/DIV, raw value for MULTU/DIVU) and the result sign bits, then moves to CALC with count=0.
  - stall=0 in IDLE.
- State CALC (multiply): radix-2 shift-add, one iteration per clock, 2*WIDTH-bit accumulator.
- State CALC (divide): restoring divide, one quotient bit per clock.
- CALC exit: when count reaches WIDTH-1, the next edge moves to DONE. CALC therefore lasts exactly WIDTH cycles.
- State DONE: applies sign fixup and holds it for one cycle, with hi_we=lo_we=1 and hi_wdata/lo_wdata valid. The next edge writes HI/LO and returns to IDLE.
- Latency: start is sampled at edge E0; HI/LO are written at edge E(WIDTH+1), i.e. E33 for WIDTH=32. A CPU read in the cycle after E33 sees the new values.
- Sign rules:
  - MULT: the product is negated when the operand signs differ.
  - DIV: the quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This is wrap-around and is not flagged.
- Divide by zero: LO=all ones, HI=rs_val (the original, unsigned-interpreted value), div_zero=1 in DONE. No exception is raised.
- Stall: stall = busy & (start | mfhi | mflo | mthi | mtlo). A start raised while busy is ignored and the CPU holds it until IDLE.
- Simultaneous mthi/mtlo with hi_we/lo_we cannot occur, because mthi/mtlo stall throughout CALC and DONE.
- Operands are captured at E0; later changes to rs_val/rt_val have no effect.
- Reset mid-operation abandons the operation with no HI/LO write.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state encodings ST_IDLE, ST_CALC, ST_DONE.
- One sub-module is natural: muldiv_core, the shift-add/restoring datapath step. Its inputs are acc, divisor/multiplicand and mode; its outputs are next acc.
- The FSM, counter and stall logic stay in muldiv_seq.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi_we/lo_we high exactly 33 cycles after start, with HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 -> LO=14, HI=2. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234, div_zero pulse of exactly one cycle.
- mfhi asserted 5 cycles after start -> stall=1 until the cycle after the write edge. A second start during CALC -> stalled, then accepted on the first IDLE cycle, producing a second result 33 cycles later.
- Assert rst low at cycle 10 of CALC -> busy, stall, hi_we and lo_we drop immediately, no write occurs, and the next start completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation encodings, FSM state encoding and small decode helpers.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // True for DIV and DIVU.
   function automatic logic op_is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // True for the two's-complement flavours MULT and DIV.
   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the unsigned multiply/divide datapath.
// Multiply: acc = {partial product, remaining multiplier bits}; radix-2 shift-add.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits}; restoring.
module muldiv_core #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   input  logic               is_div,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       rem_shift;
   logic [WIDTH:0]       rem_diff;
   logic [2*WIDTH-1:0]   mul_next;
   logic [2*WIDTH-1:0]   div_next;

   // Compute both step candidates and select the one for the active mode.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      mul_next  = {mul_sum, acc[WIDTH-1:1]};

      rem_shift = acc[2*WIDTH-1:WIDTH-1];
      rem_diff  = rem_shift - {1'b0, operand};
      if (!rem_diff[WIDTH]) begin
         div_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         div_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end

      acc_next = is_div ? div_next : mul_next;
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer producing HI/LO write data and
// enables, plus the CPU interlock that keeps hi/lo accesses and new mul/div
// ops from racing an operation in flight.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             mfhi,
   input  logic             mflo,
   input  logic             mthi,
   input  logic             mtlo,
   output logic             busy,
   output logic             stall,
   output logic             hi_we,
   output logic             lo_we,
   output logic [WIDTH-1:0] hi_wdata,
   output logic [WIDTH-1:0] lo_wdata,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t               state, state_next;
   logic [1:0]           op_q;
   logic [CW-1:0]        count;
   logic [2*WIDTH-1:0]   acc, acc_next;
   logic [WIDTH-1:0]     operand_q;
   logic [WIDTH-1:0]     rs_raw_q;
   logic                 neg_lo_q;
   logic                 neg_hi_q;
   logic                 div_zero_q;
   logic                 is_div_q;

   logic                 cap_div;
   logic                 rs_neg, rt_neg;
   logic [WIDTH-1:0]     rs_mag, rt_mag;
   logic [2*WIDTH-1:0]   prod_fix;

   assign is_div_q = op_is_div(op_q);

   muldiv_core #(.WIDTH(WIDTH)) u_core (
      .acc      (acc),
      .operand  (operand_q),
      .is_div   (is_div_q),
      .acc_next (acc_next)
   );

   // Operand preparation: magnitudes and sign bits for the incoming op.
   always_comb begin
      cap_div = op_is_div(op);
      rs_neg  = op_is_signed(op) & rs_val[WIDTH-1];
      rt_neg  = op_is_signed(op) & rt_val[WIDTH-1];
      rs_mag  = rs_neg ? -rs_val : rs_val;
      rt_mag  = rt_neg ? -rt_val : rt_val;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: IDLE -> CALC for WIDTH iterations -> one DONE cycle.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start) state_next = ST_CALC;
         ST_CALC: if (count == LAST) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Datapath registers: capture on accepted start, iterate during CALC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q       <= '0;
         count      <= '0;
         acc        <= '0;
         operand_q  <= '0;
         rs_raw_q   <= '0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q       <= op;
                  count      <= '0;
                  rs_raw_q   <= rs_val;
                  neg_lo_q   <= rs_neg ^ rt_neg;
                  neg_hi_q   <= cap_div ? rs_neg : (rs_neg ^ rt_neg);
                  div_zero_q <= cap_div && (rt_val == '0);
                  if (cap_div) begin
                     acc       <= {{WIDTH{1'b0}}, rs_mag};
                     operand_q <= rt_mag;
                  end else begin
                     acc       <= {{WIDTH{1'b0}}, rt_mag};
                     operand_q <= rs_mag;
                  end
               end
            end
            ST_CALC: begin
               acc   <= acc_next;
               count <= count + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Outputs: interlock, and sign-fixed write data held through DONE.
   always_comb begin
      busy     = (state != ST_IDLE);
      stall    = busy & (start | mfhi | mflo | mthi | mtlo);
      hi_we    = 1'b0;
      lo_we    = 1'b0;
      hi_wdata = '0;
      lo_wdata = '0;
      div_zero = 1'b0;
      prod_fix = neg_lo_q ? -acc : acc;
      if (state == ST_DONE) begin
         hi_we    = 1'b1;
         lo_we    = 1'b1;
         div_zero = div_zero_q;
         if (div_zero_q) begin
            hi_wdata = rs_raw_q;
            lo_wdata = '1;
         end else if (is_div_q) begin
            hi_wdata = neg_hi_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            lo_wdata = neg_lo_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         end else begin
            hi_wdata = prod_fix[2*WIDTH-1:WIDTH];
            lo_wdata = prod_fix[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (WIDTH = 32).
module tb_muldiv_seq;
   import muldiv_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        mfhi, mflo, mthi, mtlo;
   logic        busy, stall, hi_we, lo_we, div_zero;
   logic [31:0] hi_wdata, lo_wdata;

   int errors = 0;
   int checks = 0;

   muldiv_seq #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .mfhi     (mfhi),
      .mflo     (mflo),
      .mthi     (mthi),
      .mtlo     (mtlo),
      .busy     (busy),
      .stall    (stall),
      .hi_we    (hi_we),
      .lo_we    (lo_we),
      .hi_wdata (hi_wdata),
      .lo_wdata (lo_wdata),
      .div_zero (div_zero)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one op for a single edge (E0), then scramble the operand buses.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      @(posedge clk);
      #1;
      start  = 1'b0;
      rs_val = 32'hDEADBEEF;
      rt_val = 32'h00000003;
   endtask

   // Step edges until hi_we is seen; n is the number of edges since the call.
   task automatic wait_we(output int n);
      n = 0;
      while (n < 80) begin
         @(posedge clk);
         #1;
         n++;
         if (hi_we) break;
      end
      checks++;
      if (!hi_we) begin
         errors++;
         $display("[TB] FAIL wait_we timeout: hi_we=%0b after %0d cycles, required 1", hi_we, n);
      end
   endtask

   task automatic test_reset();
      rst   = 1'b0;
      start = 1'b1;
      op    = OP_MULTU;
      rs_val = 32'h5;
      rt_val = 32'h6;
      mfhi = 1'b1; mflo = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      #22;
      checks++;
      if ({busy, stall, hi_we, lo_we, div_zero} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b, required 00000", {busy, stall, hi_we, lo_we, div_zero});
      end
      checks++;
      if ({hi_wdata, lo_wdata} !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reset_wdata: got %h, required 0", {hi_wdata, lo_wdata});
      end
      start = 1'b0;
      mfhi  = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_multu();
      int n;
      issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_we(n);
      checks++;
      if (n !== 32) begin
         errors++;
         $display("[TB] FAIL multu_latency: hi_we after %0d edges, required 32", n);
      end
      checks++;
      if ({hi_we, lo_we, hi_wdata, lo_wdata} !== {2'b11, 64'hFFFFFFFE_00000001}) begin
         errors++;
         $display("[TB] FAIL multu_result: got we=%b%b %h_%h, required 11 FFFFFFFE_00000001",
                  hi_we, lo_we, hi_wdata, lo_wdata);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({busy, hi_we, lo_we} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL multu_after_write: busy/hi_we/lo_we=%b, required 000", {busy, hi_we, lo_we});
      end
   endtask

   task automatic test_mult();
      int n;
      logic [31:0] a, b, eh, el;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: begin a = 32'hFFFFFFFD; b = 32'd7;        eh = 32'hFFFFFFFF; el = 32'hFFFFFFEB; end
            1: begin a = 32'h80000000; b = 32'h80000000; eh = 32'h40000000; el = 32'h00000000; end
            default: begin a = 32'd1000; b = 32'hFFFFFFFE; eh = 32'hFFFFFFFF; el = 32'hFFFFF830; end
         endcase
         issue(OP_MULT, a, b);
         wait_we(n);
         checks++;
         if ({n[7:0], hi_wdata, lo_wdata} !== {8'd32, eh, el}) begin
            errors++;
            $display("[TB] FAIL mult_%0d: got n=%0d %h_%h, required n=32 %h_%h",
                     i, n, hi_wdata, lo_wdata, eh, el);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_div();
      int n;
      logic [1:0]  o;
      logic [31:0] a, b, eh, el;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin o = OP_DIV;  a = 32'hFFFFFFF9; b = 32'd2;        eh = 32'hFFFFFFFF; el = 32'hFFFFFFFD; end
            1: begin o = OP_DIVU; a = 32'd100;      b = 32'd7;        eh = 32'd2;        el = 32'd14;       end
            2: begin o = OP_DIV;  a = 32'h80000000; b = 32'hFFFFFFFF; eh = 32'h0;        el = 32'h80000000; end
            default: begin o = OP_DIV; a = 32'd7;   b = 32'hFFFFFFFE; eh = 32'd1;        el = 32'hFFFFFFFD; end
         endcase
         issue(o, a, b);
         wait_we(n);
         checks++;
         if ({n[7:0], div_zero, hi_wdata, lo_wdata} !== {8'd32, 1'b0, eh, el}) begin
            errors++;
            $display("[TB] FAIL div_%0d: got n=%0d dz=%b %h_%h, required n=32 dz=0 %h_%h",
                     i, n, div_zero, hi_wdata, lo_wdata, eh, el);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_div_zero();
      int n;
      int dz;
      issue(OP_DIVU, 32'h00001234, 32'h0);
      n  = 0;
      dz = 0;
      while (n < 80) begin
         @(posedge clk);
         #1;
         n++;
         if (div_zero) dz++;
         if (hi_we) break;
      end
      checks++;
      if ({n[7:0], hi_wdata, lo_wdata} !== {8'd32, 32'h00001234, 32'hFFFFFFFF}) begin
         errors++;
         $display("[TB] FAIL divzero_result: got n=%0d %h_%h, required n=32 00001234_FFFFFFFF",
                  n, hi_wdata, lo_wdata);
      end
      @(posedge clk);
      #1;
      if (div_zero) dz++;
      checks++;
      if (dz !== 1) begin
         errors++;
         $display("[TB] FAIL divzero_pulse: div_zero high %0d cycles, required 1", dz);
      end
   endtask

   task automatic test_mfhi_stall();
      int n;
      int hi_cnt;
      issue(OP_MULTU, 32'd5, 32'd6);
      repeat (5) @(posedge clk);
      #1;
      mfhi   = 1'b1;
      n      = 5;
      hi_cnt = 0;
      while (n < 80) begin
         @(posedge clk);
         #1;
         n++;
         if (stall) hi_cnt++;
         if (hi_we) break;
      end
      checks++;
      if ({n[7:0], hi_cnt[7:0], lo_wdata} !== {8'd32, 8'd27, 32'd30}) begin
         errors++;
         $display("[TB] FAIL mfhi_stall_calc: got n=%0d stalls=%0d lo=%h, required 32 27 0000001e",
                  n, hi_cnt, lo_wdata);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({stall, busy} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL mfhi_stall_release: stall/busy=%b, required 00", {stall, busy});
      end
      mfhi = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n;
      issue(OP_MULTU, 32'd5, 32'd6);
      repeat (3) @(posedge clk);
      #1;
      start  = 1'b1;
      op     = OP_DIVU;
      rs_val = 32'd100;
      rt_val = 32'd7;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_stall: got %b, required 1", stall);
      end
      wait_we(n);
      checks++;
      if ({n[7:0], hi_wdata, lo_wdata} !== {8'd29, 32'd0, 32'd30}) begin
         errors++;
         $display("[TB] FAIL b2b_first: got n=%0d %h_%h, required n=29 00000000_0000001e",
                  n, hi_wdata, lo_wdata);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({busy, stall} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL b2b_idle: busy/stall=%b, required 00", {busy, stall});
      end
      @(posedge clk);
      #1;
      start  = 1'b0;
      rs_val = 32'hDEADBEEF;
      rt_val = 32'h3;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_accept: busy=%b, required 1", busy);
      end
      wait_we(n);
      checks++;
      if ({n[7:0], hi_wdata, lo_wdata} !== {8'd32, 32'd2, 32'd14}) begin
         errors++;
         $display("[TB] FAIL b2b_second: got n=%0d %h_%h, required n=32 00000002_0000000e",
                  n, hi_wdata, lo_wdata);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int n;
      int we_seen;
      issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (10) @(posedge clk);
      #1;
      mfhi = 1'b1;
      #1;
      checks++;
      if ({busy, stall} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL rstmid_before: busy/stall=%b, required 11", {busy, stall});
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({busy, stall, hi_we, lo_we} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL rstmid_async: busy/stall/hi_we/lo_we=%b, required 0000",
                  {busy, stall, hi_we, lo_we});
      end
      mfhi = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      we_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (hi_we || lo_we || busy) we_seen++;
      end
      checks++;
      if (we_seen !== 0) begin
         errors++;
         $display("[TB] FAIL rstmid_nowrite: %0d active cycles, required 0", we_seen);
      end
      issue(OP_DIVU, 32'd100, 32'd7);
      wait_we(n);
      checks++;
      if ({n[7:0], hi_wdata, lo_wdata} !== {8'd32, 32'd2, 32'd14}) begin
         errors++;
         $display("[TB] FAIL rstmid_next: got n=%0d %h_%h, required n=32 00000002_0000000e",
                  n, hi_wdata, lo_wdata);
      end
      @(posedge clk);
      #1;
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_div_zero();
      test_mfhi_stall();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
